opp_state_rx: RTL and testbench

//  Upstream of the game-logic stage. Parses the opponent-state packet byte stream from the

---
 rtl/opp_state_rx_if.sv | 9 +
 rtl/opp_state_rx.sv | 179 +++++++++++++++++
 tb/tb_opp_state_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/opp_state_rx_if.sv
// Opponent-state RX byte stream: one byte per rx_valid cycle, rx_last marks the packet end.
interface opp_state_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;

    modport master (output rx_valid, output rx_data, output rx_last);
    modport slave  (input  rx_valid, input  rx_data, input  rx_last);
endinterface

// File: rtl/opp_state_rx.sv
// Opponent-state packet parser: validates 9-byte packets, stages the last good one and
// publishes it on frame_tick. Optional link-loss timeout under macro OPP_RX_TIMEOUT_EN.
module opp_state_rx #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter logic [10:0] RST_X  = 11'd256,
    parameter logic [10:0] RST_Y  = 11'd100,
    parameter int unsigned TIMEOUT_FRAMES = 120
) (
    input  logic           clk,
    input  logic           rst_n,
    opp_state_rx_if.slave  rx,
    input  logic           frame_tick,
    output logic [10:0]    r_opp_x,
    output logic [10:0]    r_opp_y,
    output logic [8:0]     r_opp_dir,
    output logic [2:0]     r_opp_game,
    output logic           r_opp_rst,
    output logic           opp_valid,
    output logic [7:0]     pkt_ok_cnt,
    output logic [7:0]     pkt_err_cnt
);
    typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [10:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
    logic [8:0]  cap_dir_q, cap_dir_d;
    logic [3:0]  cap_flg_q, cap_flg_d;
    logic        good_d, good_q, err_d, err_q;

    logic [10:0] stg_x_q, stg_y_q;
    logic [8:0]  stg_dir_q;
    logic [3:0]  stg_flg_q;
    logic        new_q;
    logic        publish;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        cap_x_d   = cap_x_q;
        cap_y_d   = cap_y_q;
        cap_dir_d = cap_dir_q;
        cap_flg_d = cap_flg_q;
        good_d    = 1'b0;
        err_d     = 1'b0;
        if (rx.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx.rx_data == HEADER && !rx.rx_last) begin
                        state_d = BODY;
                        idx_d   = 4'd1;
                        xor_d   = HEADER;
                    end
                end
                BODY: begin
                    if (idx_q == 4'd8) begin
                        // Checksum byte: decide the packet on this same cycle
                        if (rx.rx_last) begin
                            state_d = IDLE;
                            if (rx.rx_data == xor_q && cap_dir_q < 9'd360) good_d = 1'b1;
                            else                                           err_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            err_d   = 1'b1;
                        end
                    end else begin
                        case (idx_q)
                            4'd1:    cap_x_d[10:8]  = rx.rx_data[2:0];
                            4'd2:    cap_x_d[7:0]   = rx.rx_data;
                            4'd3:    cap_y_d[10:8]  = rx.rx_data[2:0];
                            4'd4:    cap_y_d[7:0]   = rx.rx_data;
                            4'd5:    cap_dir_d[8]   = rx.rx_data[0];
                            4'd6:    cap_dir_d[7:0] = rx.rx_data;
                            default: cap_flg_d      = rx.rx_data[3:0];
                        endcase
                        xor_d = xor_q ^ rx.rx_data;
                        idx_d = idx_q + 4'd1;
                        if (rx.rx_last) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rx.rx_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            xor_q     <= 8'd0;
            cap_x_q   <= 11'd0;
            cap_y_q   <= 11'd0;
            cap_dir_q <= 9'd0;
            cap_flg_q <= 4'd0;
            good_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            cap_x_q   <= cap_x_d;
            cap_y_q   <= cap_y_d;
            cap_dir_q <= cap_dir_d;
            cap_flg_q <= cap_flg_d;
            good_q    <= good_d;
            err_q     <= err_d;
        end
    end

    // A tick coinciding with a staging write publishes the previous staging contents
    assign publish = frame_tick && new_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_x_q     <= RST_X;
            stg_y_q     <= RST_Y;
            stg_dir_q   <= 9'd0;
            stg_flg_q   <= 4'd0;
            new_q       <= 1'b0;
            r_opp_x     <= RST_X;
            r_opp_y     <= RST_Y;
            r_opp_dir   <= 9'd0;
            r_opp_game  <= 3'd0;
            r_opp_rst   <= 1'b0;
            pkt_ok_cnt  <= 8'd0;
            pkt_err_cnt <= 8'd0;
        end else begin
            if (good_q) begin
                stg_x_q   <= cap_x_q;
                stg_y_q   <= cap_y_q;
                stg_dir_q <= cap_dir_q;
                stg_flg_q <= cap_flg_q;
            end
            if (good_q)         new_q <= 1'b1;
            else if (publish)   new_q <= 1'b0;
            if (publish) begin
                r_opp_x    <= stg_x_q;
                r_opp_y    <= stg_y_q;
                r_opp_dir  <= stg_dir_q;
                r_opp_game <= stg_flg_q[2:0];
                r_opp_rst  <= stg_flg_q[3];
            end
            if (good_q && pkt_ok_cnt != 8'hFF)  pkt_ok_cnt  <= pkt_ok_cnt + 8'd1;
            if (err_q && pkt_err_cnt != 8'hFF)  pkt_err_cnt <= pkt_err_cnt + 8'd1;
        end
    end

`ifdef OPP_RX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_FRAMES);
    logic [CW-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            opp_valid <= 1'b0;
        end else if (publish) begin
            tmo_cnt_q <= '0;
            opp_valid <= 1'b1;
        end else if (frame_tick && tmo_cnt_q != TO_LIM) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TO_LIM - 1'b1) opp_valid <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n)       opp_valid <= 1'b0;
        else if (publish) opp_valid <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_opp_state_rx.sv
// Directed bench for opp_state_rx; run with or without OPP_RX_TIMEOUT_EN.
module tb_opp_state_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [10:0] r_opp_x, r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        r_opp_rst, opp_valid;
    logic [7:0]  pkt_ok_cnt, pkt_err_cnt;
    int          n_pass = 0;
    int          n_total = 0;

    opp_state_rx_if rx_if ();

    always #5 clk = ~clk;

    opp_state_rx #(.TIMEOUT_FRAMES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_if),
        .frame_tick (frame_tick),
        .r_opp_x    (r_opp_x),
        .r_opp_y    (r_opp_y),
        .r_opp_dir  (r_opp_dir),
        .r_opp_game (r_opp_game),
        .r_opp_rst  (r_opp_rst),
        .opp_valid  (opp_valid),
        .pkt_ok_cnt (pkt_ok_cnt),
        .pkt_err_cnt(pkt_err_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input int x, input int y, input int dir,
                            input int game, input int rst, input int vld);
        chk({tag, ".x"},    32'(r_opp_x),    32'(x));
        chk({tag, ".y"},    32'(r_opp_y),    32'(y));
        chk({tag, ".dir"},  32'(r_opp_dir),  32'(dir));
        chk({tag, ".game"}, 32'(r_opp_game), 32'(game));
        chk({tag, ".rst"},  32'(r_opp_rst),  32'(rst));
        chk({tag, ".vld"},  32'(opp_valid),  32'(vld));
    endtask

    task automatic chk_cnt(input string tag, input int ok, input int err);
        chk({tag, ".ok"},  32'(pkt_ok_cnt),  32'(ok));
        chk({tag, ".err"}, 32'(pkt_err_cnt), 32'(err));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = d;
        rx_if.rx_last  = last;
        cyc();
        rx_if.rx_valid = 1'b0;
        rx_if.rx_last  = 1'b0;
        rx_if.rx_data  = 8'h00;
    endtask

    // nbytes <9 truncates, >9 pads with header-valued bytes that must be drained
    task automatic send_pkt(input logic [10:0] x, input logic [10:0] y, input logic [8:0] dir,
                            input logic [2:0] game, input logic rst, input logic [7:0] chk_flip,
                            input int nbytes, input bit gaps);
        logic [7:0] b [0:8];
        b[0] = 8'hA5;
        b[1] = {5'd0, x[10:8]};
        b[2] = x[7:0];
        b[3] = {5'd0, y[10:8]};
        b[4] = y[7:0];
        b[5] = {7'd0, dir[8]};
        b[6] = dir[7:0];
        b[7] = {4'd0, rst, game};
        b[8] = chk_flip;
        for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && i > 0) idle(1 + (i % 2));
            send_byte((i < 9) ? b[i] : 8'hA5, i == nbytes - 1);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_last  = 1'b0;
        rx_if.rx_data  = 8'h00;
        idle(2);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        do_reset();
        chk_outs("reset", 256, 100, 0, 0, 0, 0);
        chk_cnt("reset", 0, 0);

        // Bad checksum: nothing published
        send_pkt(11'd300, 11'd450, 9'd90, 3'd0, 1'b0, 8'h01, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("badchk", 256, 100, 0, 0, 0, 0);
        chk_cnt("badchk", 0, 1);

        // Good packet, held until the tick
        do_reset();
        send_pkt(11'd300, 11'd450, 9'd90, 3'd0, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        chk("good.pretick_x", 32'(r_opp_x), 32'd256);
        tick();
        chk_outs("good", 300, 450, 90, 0, 0, 1);
        chk_cnt("good", 1, 0);

        // dir=360 rejected, truncated packet rejected, then FSM accepts a good one
        do_reset();
        send_pkt(11'd1, 11'd2, 9'd360, 3'd1, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        chk_cnt("dir360", 0, 1);
        send_pkt(11'd1, 11'd2, 9'd10, 3'd1, 1'b0, 8'h00, 6, 1'b0);
        idle(2);
        chk_cnt("trunc", 0, 2);
        send_pkt(11'd5, 11'd6, 9'd359, 3'd7, 1'b1, 8'h00, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("dir359", 5, 6, 359, 7, 1, 1);
        chk_cnt("dir359", 1, 2);

        // Staging write on the tick cycle publishes the previous staging
        send_pkt(11'd11, 11'd22, 9'd33, 3'd2, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        send_pkt(11'd1000, 11'd2000, 9'd180, 3'd3, 1'b0, 8'h00, 9, 1'b0);
        tick();
        chk_outs("conflict.old", 11, 22, 33, 2, 0, 1);
        idle(1);
        tick();
        chk_outs("conflict.new", 1000, 2000, 180, 3, 0, 1);
        chk_cnt("conflict", 3, 2);

        // Last good packet between ticks wins
        send_pkt(11'd7, 11'd8, 9'd9, 3'd4, 1'b0, 8'h00, 9, 1'b0);
        send_pkt(11'd70, 11'd80, 9'd300, 3'd5, 1'b1, 8'h00, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("lastwins", 70, 80, 300, 5, 1, 1);

        // Garbage then a stalled good packet; then an over-long packet drained
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b1);
        send_pkt(11'd2047, 11'd0, 9'd45, 3'd6, 1'b0, 8'h00, 9, 1'b1);
        idle(2);
        tick();
        chk_outs("gaps", 2047, 0, 45, 6, 0, 1);
        chk_cnt("gaps", 1, 0);
        send_pkt(11'd3, 11'd4, 9'd5, 3'd0, 1'b0, 8'h00, 12, 1'b0);
        idle(1);
        chk_cnt("long", 1, 1);
        send_pkt(11'd123, 11'd456, 9'd200, 3'd1, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("afterdrain", 123, 456, 200, 1, 0, 1);
        chk_cnt("afterdrain", 2, 1);

        // Reset mid-packet: partial dropped and not counted
        send_pkt(11'd9, 11'd9, 9'd9, 3'd0, 1'b0, 8'h00, 4, 1'b0);
        do_reset();
        chk_cnt("midrst", 0, 0);
        send_pkt(11'd400, 11'd500, 9'd1, 3'd2, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("midrst", 400, 500, 1, 2, 0, 1);
        chk_cnt("midrst.after", 1, 0);

        // Empty ticks: timeout after 3 with the macro, otherwise valid holds
        idle(1);
        tick();
        idle(1);
        tick();
        chk("tmo.two_ticks", 32'(opp_valid), 32'd1);
        idle(1);
        tick();
        idle(1);
`ifdef OPP_RX_TIMEOUT_EN
        chk_outs("tmo.lost", 400, 500, 1, 2, 0, 0);
        send_pkt(11'd600, 11'd700, 9'd2, 3'd3, 1'b0, 8'h00, 9, 1'b0);
        idle(2);
        tick();
        chk_outs("tmo.back", 600, 700, 2, 3, 0, 1);
`else
        tick();
        idle(1);
        chk_outs("notmo", 400, 500, 1, 2, 0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
